// File: rtl/niu32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : niu32_pkg
// Purpose  : Shared word size, memory-mapped I/O addresses and register
//            selector used by the CPU and the I/O responder.
// Revision : 1.0 - initial release
// ============================================================================
package niu32_pkg;

    localparam int          c_word_size   = 32;
    localparam logic [31:0] c_addr_hex    = 32'hFFFF0000;
    localparam logic [31:0] c_addr_ledr   = 32'hFFFF0020;
    localparam logic [31:0] c_addr_ledg   = 32'hFFFF0040;
    localparam logic [31:0] c_addr_key    = 32'hFFFF0100;
    localparam logic [31:0] c_addr_switch = 32'hFFFF0120;

    typedef enum logic [2:0] {
        IO_NONE   = 3'd0,
        IO_HEX    = 3'd1,
        IO_LEDR   = 3'd2,
        IO_LEDG   = 3'd3,
        IO_KEY    = 3'd4,
        IO_SWITCH = 3'd5
    } io_reg_e;

endpackage
`default_nettype wire

// File: rtl/niu32_sync2.sv
`default_nettype none
// ============================================================================
// Module   : niu32_sync2
// Purpose  : Two-flop synchronizer for asynchronous board inputs.
// Revision : 1.0 - initial release
// ============================================================================
module niu32_sync2
    import niu32_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/niu32_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : niu32_io_responder
// Purpose  : Memory-mapped board I/O: HEX/LED output registers, key edge
//            capture and switch readback, single-cycle acked CPU access.
// Revision : 1.0 - initial release
// ============================================================================
module niu32_io_responder
    import niu32_pkg::*;
#(
    parameter int                   WORD_SIZE   = c_word_size,
    parameter logic [WORD_SIZE-1:0] ADDR_HEX    = c_addr_hex,
    parameter logic [WORD_SIZE-1:0] ADDR_LEDR   = c_addr_ledr,
    parameter logic [WORD_SIZE-1:0] ADDR_LEDG   = c_addr_ledg,
    parameter logic [WORD_SIZE-1:0] ADDR_KEY    = c_addr_key,
    parameter logic [WORD_SIZE-1:0] ADDR_SWITCH = c_addr_switch
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic                 we,
    input  logic                 re,
    output logic                 io_sel,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 ack,
    input  logic [3:0]           key_n,
    input  logic [9:0]           sw,
    output logic [15:0]          hex_val,
    output logic [9:0]           ledr,
    output logic [7:0]           ledg
);

    logic [3:0]           w_key_sync;
    logic [9:0]           w_sw_sync;
    logic [3:0]           w_key_lvl;
    logic [3:0]           w_key_set;
    logic [3:0]           w_key_clr;
    io_reg_e              w_sel;
    logic [WORD_SIZE-1:0] w_rd_data;
    logic [WORD_SIZE-1:0] w_unused_wdata;

    logic                 r_ack;
    logic [WORD_SIZE-1:0] r_rdata;
    logic [15:0]          r_hex;
    logic [9:0]           r_ledr;
    logic [7:0]           r_ledg;
    logic [3:0]           r_key_edge;
    logic [3:0]           r_key_prev;
    logic [2:0]           r_settle;

    niu32_sync2 #(.WIDTH(4), .RESET_VAL(4'hF)) u_key_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key_n),
        .q     (w_key_sync)
    );

    niu32_sync2 #(.WIDTH(10), .RESET_VAL(10'h000)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw),
        .q     (w_sw_sync)
    );

    assign w_key_lvl      = ~w_key_sync;
    assign io_sel         = (addr[WORD_SIZE-1 -: 16] == 16'hFFFF);
    assign w_unused_wdata = wdata;

    always_comb begin
        w_sel = IO_NONE;
        if      (addr == ADDR_HEX)    w_sel = IO_HEX;
        else if (addr == ADDR_LEDR)   w_sel = IO_LEDR;
        else if (addr == ADDR_LEDG)   w_sel = IO_LEDG;
        else if (addr == ADDR_KEY)    w_sel = IO_KEY;
        else if (addr == ADDR_SWITCH) w_sel = IO_SWITCH;
    end

    always_comb begin
        w_rd_data = '0;
        case (w_sel)
            IO_HEX:    w_rd_data[15:0] = r_hex;
            IO_LEDR:   w_rd_data[9:0]  = r_ledr;
            IO_LEDG:   w_rd_data[7:0]  = r_ledg;
            IO_KEY:    w_rd_data[7:0]  = {r_key_edge, w_key_lvl};
            IO_SWITCH: w_rd_data[9:0]  = w_sw_sync;
            default:   w_rd_data       = '0;
        endcase
    end

    // Edges are ignored until the synchronizer has flushed its reset value
    // and r_key_prev holds a real sample, so a key held through reset is not
    // mistaken for a fresh press.
    assign w_key_set = r_settle[2] ? (w_key_lvl & ~r_key_prev) : 4'b0000;
    assign w_key_clr = (we && (w_sel == IO_KEY)) ? wdata[7:4] : 4'b0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack      <= 1'b0;
            r_rdata    <= '0;
            r_hex      <= '0;
            r_ledr     <= '0;
            r_ledg     <= '0;
            r_key_edge <= '0;
            r_key_prev <= '0;
            r_settle   <= '0;
        end else begin
            r_ack      <= re | we;
            r_rdata    <= (re && !we) ? w_rd_data : '0;
            r_key_prev <= w_key_lvl;
            r_settle   <= {r_settle[1:0], 1'b1};
            // set has priority over a same-cycle clear
            r_key_edge <= (r_key_edge & ~w_key_clr) | w_key_set;
            if (we) begin
                case (w_sel)
                    IO_HEX:  r_hex  <= wdata[15:0];
                    IO_LEDR: r_ledr <= wdata[9:0];
                    IO_LEDG: r_ledg <= wdata[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign ack     = r_ack;
    assign rdata   = r_rdata;
    assign hex_val = r_hex;
    assign ledr    = r_ledr;
    assign ledg    = r_ledg;

endmodule
`default_nettype wire

// File: tb/tb_niu32_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_niu32_io_responder
// Purpose  : Directed, table-driven self-checking bench for niu32_io_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_niu32_io_responder;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        io_sel;
    logic [31:0] rdata;
    logic        ack;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    logic [15:0] hex_val;
    logic [9:0]  ledr;
    logic [7:0]  ledg;

    int cmp_cnt;
    int fail_cnt;

    niu32_io_responder dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .re      (re),
        .io_sel  (io_sel),
        .rdata   (rdata),
        .ack     (ack),
        .key_n   (key_n),
        .sw      (sw),
        .hex_val (hex_val),
        .ledr    (ledr),
        .ledg    (ledg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [15:0] exp_hex;
        logic [9:0]  exp_ledr;
        logic [7:0]  exp_ledg;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives one request, samples ack/rdata #1 after the
    // accepting edge's following edge result, returns at the next negedge idle.
    task automatic do_req(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, output logic ack_o, output logic [31:0] rd_o);
        we = w; re = r; addr = a; wdata = d;
        @(posedge clk); #1;
        ack_o = ack;
        rd_o  = rdata;
        @(negedge clk);
        we = 1'b0; re = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic load_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic        k;
        logic [31:0] d;
        do_req(1'b0, 1'b1, a, 32'h0, k, d);
        check({name, "_ack"}, {31'b0, k}, 32'h1);
        check({name, "_rdata"}, d, exp);
    endtask

    task automatic store_check(input string name, input logic [31:0] a, input logic [31:0] v);
        logic        k;
        logic [31:0] d;
        do_req(1'b1, 1'b0, a, v, k, d);
        check({name, "_ack"}, {31'b0, k}, 32'h1);
        check({name, "_rdata"}, d, 32'h0);
    endtask

    initial begin
        logic        k;
        logic [31:0] d;
        logic [31:0] last_w;
        int          acks;

        cmp_cnt = 0; fail_cnt = 0;
        reset = 1'b1; we = 1'b0; re = 1'b0; addr = 32'h0; wdata = 32'h0;
        key_n = 4'hF; sw = 10'h2A5;

        //                we    re    addr           wdata          rdata          hex       ledr     ledg
        vecs[0]  = '{1'b1, 1'b0, 32'hFFFF0000, 32'h0000BEEF, 32'h00000000, 16'hBEEF, 10'h000, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 32'hFFFF0000, 32'h00000000, 32'h0000BEEF, 16'hBEEF, 10'h000, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 32'hFFFF0020, 32'hFFFFFFFF, 32'h00000000, 16'hBEEF, 10'h3FF, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 32'hFFFF0020, 32'h00000000, 32'h000003FF, 16'hBEEF, 10'h3FF, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 32'hFFFF0040, 32'h12345678, 32'h00000000, 16'hBEEF, 10'h3FF, 8'h78};
        vecs[5]  = '{1'b0, 1'b1, 32'hFFFF0040, 32'h00000000, 32'h00000078, 16'hBEEF, 10'h3FF, 8'h78};
        vecs[6]  = '{1'b0, 1'b1, 32'hFFFF0124, 32'h00000000, 32'h00000000, 16'hBEEF, 10'h3FF, 8'h78};
        vecs[7]  = '{1'b1, 1'b0, 32'h00001000, 32'hFFFFFFFF, 32'h00000000, 16'hBEEF, 10'h3FF, 8'h78};
        vecs[8]  = '{1'b1, 1'b0, 32'hFFFF0001, 32'hFFFFFFFF, 32'h00000000, 16'hBEEF, 10'h3FF, 8'h78};
        vecs[9]  = '{1'b1, 1'b1, 32'hFFFF0000, 32'h00001234, 32'h00000000, 16'h1234, 10'h3FF, 8'h78};
        vecs[10] = '{1'b0, 1'b1, 32'hFFFF0120, 32'h00000000, 32'h000002A5, 16'h1234, 10'h3FF, 8'h78};
        vecs[11] = '{1'b0, 1'b1, 32'hFFFF0100, 32'h00000000, 32'h00000000, 16'h1234, 10'h3FF, 8'h78};
        vecs[12] = '{1'b0, 1'b1, 32'hFFFF0022, 32'h00000000, 32'h00000000, 16'h1234, 10'h3FF, 8'h78};
        vecs[13] = '{1'b0, 1'b1, 32'hFFFF0000, 32'h00000000, 32'h00001234, 16'h1234, 10'h3FF, 8'h78};
        vecs[14] = '{1'b1, 1'b0, 32'hFFFF0120, 32'h00000000, 32'h00000000, 16'h1234, 10'h3FF, 8'h78};
        vecs[15] = '{1'b0, 1'b1, 32'hFFFF0120, 32'h00000000, 32'h000002A5, 16'h1234, 10'h3FF, 8'h78};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ack",   {31'b0, ack}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_hex",   {16'b0, hex_val}, 32'h0);
        check("rst_ledr",  {22'b0, ledr}, 32'h0);
        check("rst_ledg",  {24'b0, ledg}, 32'h0);
        addr = 32'hFFFF0120; #1;
        check("io_sel_hi", {31'b0, io_sel}, 32'h1);
        addr = 32'hFFFE0000; #1;
        check("io_sel_lo", {31'b0, io_sel}, 32'h0);
        addr = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // table-driven single requests
        for (int i = 0; i < 16; i++) begin
            do_req(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, k, d);
            check($sformatf("vec%0d_ack", i), {31'b0, k}, 32'h1);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            check($sformatf("vec%0d_hex", i), {16'b0, hex_val}, {16'b0, vecs[i].exp_hex});
            check($sformatf("vec%0d_ledr", i), {22'b0, ledr}, {22'b0, vecs[i].exp_ledr});
            check($sformatf("vec%0d_ledg", i), {24'b0, ledg}, {24'b0, vecs[i].exp_ledg});
        end
        @(posedge clk); #1;
        check("ack_idle", {31'b0, ack}, 32'h0);
        @(negedge clk);

        // key press, edge capture and clear
        key_n = 4'b1011;
        repeat (3) @(negedge clk);
        load_check("key2_press", 32'hFFFF0100, 32'h00000044);
        store_check("key2_clr", 32'hFFFF0100, 32'h00000040);
        load_check("key2_after_clr", 32'hFFFF0100, 32'h00000004);
        key_n = 4'hF;
        repeat (4) @(negedge clk);
        load_check("key2_release", 32'hFFFF0100, 32'h00000000);

        // press edge lands on the same clock as a clear for that bit
        key_n = 4'b1101;
        repeat (2) @(negedge clk);
        store_check("key1_coincident_clr", 32'hFFFF0100, 32'h00000020);
        load_check("key1_set_wins", 32'hFFFF0100, 32'h00000022);
        store_check("key1_clr", 32'hFFFF0100, 32'h00000020);
        load_check("key1_cleared", 32'hFFFF0100, 32'h00000002);
        key_n = 4'hF;
        repeat (4) @(negedge clk);

        // alternating write/read on consecutive cycles
        acks = 0;
        last_w = 32'h0;
        for (int i = 0; i < 8; i++) begin
            addr = 32'hFFFF0020;
            if (i % 2 == 0) begin
                we = 1'b1; re = 1'b0; wdata = 32'h00000200 + 32'(i * 17);
            end else begin
                we = 1'b0; re = 1'b1; wdata = 32'h0;
            end
            @(posedge clk); #1;
            if (ack) acks++;
            check($sformatf("alt%0d_ack", i), {31'b0, ack}, 32'h1);
            if (i % 2 == 0) begin
                check($sformatf("alt%0d_rdata", i), rdata, 32'h0);
                last_w = 32'h00000200 + 32'(i * 17);
            end else begin
                check($sformatf("alt%0d_rdata", i), rdata, last_w & 32'h3FF);
            end
            @(negedge clk);
        end
        we = 1'b0; re = 1'b0; addr = 32'h0; wdata = 32'h0;
        @(posedge clk); #1;
        check("alt_ack_after", {31'b0, ack}, 32'h0);
        check("alt_ack_count", 32'(acks), 32'd8);
        check("alt_ledr", {22'b0, ledr}, 32'h00000266);
        @(negedge clk);

        // key held through reset release must not register an edge
        key_n = 4'b1110;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst2_hex", {16'b0, hex_val}, 32'h0);
        check("rst2_ledr", {22'b0, ledr}, 32'h0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        load_check("key0_held_thru_reset", 32'hFFFF0100, 32'h00000001);
        key_n = 4'hF;
        repeat (4) @(negedge clk);
        load_check("key0_released", 32'hFFFF0100, 32'h00000000);

        // load in flight when reset asserts is dropped
        store_check("pre_rst_hex", 32'hFFFF0000, 32'h0000A5A5);
        store_check("pre_rst_ledg", 32'hFFFF0040, 32'h000000FF);
        re = 1'b1; addr = 32'hFFFF0120;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        check("inflight_ack", {31'b0, ack}, 32'h0);
        check("inflight_rdata", rdata, 32'h0);
        @(negedge clk);
        re = 1'b0; addr = 32'h0;
        @(negedge clk);
        check("rst3_hex",  {16'b0, hex_val}, 32'h0);
        check("rst3_ledg", {24'b0, ledg}, 32'h0);
        check("rst3_ledr", {22'b0, ledr}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst_ack%0d", i), {31'b0, ack}, 32'h0);
            check($sformatf("post_rst_rdata%0d", i), rdata, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/niu32_io_responder.md
NIU32_IO_RESPONDER -- requirements
Module: niu32_io_responder

Interface
REQ-001 Parameter WORD_SIZE, 32, data/address width.
REQ-002 Parameter ADDR_HEX, 32'hFFFF0000, hex-display register address.
REQ-003 Parameter ADDR_LEDR, 32'hFFFF0020, red-LED register address.
REQ-004 Parameter ADDR_LEDG, 32'hFFFF0040, green-LED register address.
REQ-005 Parameter ADDR_KEY, 32'hFFFF0100, key status/clear register address.
REQ-006 Parameter ADDR_SWITCH, 32'hFFFF0120, switch status register address.
REQ-007 clk  input  1  system clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 addr  input  32  CPU byte address; sampled when re or we is high.
REQ-010 wdata  input  32  CPU store data.
REQ-011 we  input  1  store request; one-cycle pulse.
REQ-012 re  input  1  load request; one-cycle pulse.
REQ-013 io_sel  output  1  combinational; high when addr[31:16] == 16'hFFFF.
REQ-014 rdata  output  32  registered load data; valid only while ack is high after a load.
REQ-015 ack  output  1  one-cycle completion pulse for every accepted request.
REQ-016 key_n  input  4  raw board keys, active-low, asynchronous.
REQ-017 sw  input  10  raw board switches, asynchronous.
REQ-018 hex_val  output  16  four nibbles driving the seven-segment decoders; nibble 0 drives HEX0.
REQ-019 ledr  output  10  red LEDs.
REQ-020 ledg  output  8  green LEDs.

Function
REQ-021 A request is accepted in any cycle where re or we is high; ack is high exactly one cycle later, for one cycle.
REQ-022 When re and we are both high, the request is a write; rdata holds 0 during that ack.
REQ-023 A write to ADDR_HEX sets hex_val = wdata[15:0]; a write to ADDR_LEDR sets ledr = wdata[9:0]; a write to ADDR_LEDG sets ledg = wdata[7:0]; all updates are visible the cycle after the request.
REQ-024 key_n and sw each pass through a 2-flop synchronizer; key_lvl[3:0] = inverted synchronized key_n (1 = pressed).
REQ-025 key_edge[i] is set in the cycle after key_lvl[i] goes from 0 to 1, and stays set until cleared.
REQ-026 A write to ADDR_KEY clears each key_edge[i] whose wdata[4+i] is 1; in the same cycle, a set event wins over a clear.
REQ-027 A load from ADDR_KEY returns {24'b0, key_edge, key_lvl}; a load from ADDR_SWITCH returns {22'b0, sw_sync}.
REQ-028 A load from ADDR_HEX, ADDR_LEDR or ADDR_LEDG returns the current register value, zero-extended.
REQ-029 Any address that is not mapped still produces ack; a load returns 0, and a write has no effect.
REQ-030 Address decode is exact on all 32 bits; addr[1:0] is not ignored.
REQ-031 Back-to-back requests in consecutive cycles are each acked, in order, one cycle apart; there are no wait states.

Reset
REQ-032 While reset is high: hex_val, ledr, ledg, rdata, ack and key_edge are 0; synchronizer flops hold key_n = 4'hF and sw = 0.
REQ-033 A request in flight when reset asserts is discarded; no ack is issued after reset deasserts.
REQ-034 A key that is held down through reset release does not set key_edge.

Structure
REQ-035 The I/O address constants and WORD_SIZE are defined in the shared package niu32_pkg and used by both the CPU and this block.
REQ-036 The 2-flop synchronizer is one parameterized-width sub-module, niu32_sync2, instantiated twice (keys and switches).

Verification
REQ-037 we=1, addr=FFFF0000, wdata=0000BEEF -> next cycle: ack=1 and hex_val=BEEF; then re at the same address -> rdata=0000BEEF with ack.
REQ-038 key_n[2] driven from 1 to 0 and held -> within 3 cycles a load of FFFF0100 returns 0x44; write wdata=0x40 -> the next load returns 0x04.
REQ-039 Key press edge that coincides with the clear write for the same bit -> key_edge bit remains 1.
REQ-040 Load of FFFF0124 and store to 00001000 -> ack on each, rdata=0, and ledr/ledg/hex_val unchanged.
REQ-041 sw=10'h2A5 -> a load of FFFF0120 returns 0x2A5; reset asserted one cycle after re -> no ack appears, and all outputs are 0.
REQ-042 Alternate re and we on every cycle for 8 cycles -> exactly 8 ack pulses, each carrying the correct data.
